ll_traverse_ctrl: RTL and testbench

LL_TRAVERSE_CTRL -- requirements
Module: ll_traverse_ctrl

---
 rtl/ll_pkg.sv | 20 ++
 rtl/ll_traverse_ctrl.sv | 159 +++++++++++++++
 tb/tb_ll_traverse_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ll_pkg.sv
// Shared constants and FSM encoding for the linked-list traversal controller.
// Node words carry a payload in the upper bits and a next pointer in the lower bits.
package ll_pkg;

    localparam int DATA_WIDTH    = 16;
    localparam int DATAMEM_DEPTH = 16;
    localparam int PTR_WD        = $clog2(DATAMEM_DEPTH);

    // All-ones pointer terminates a list
    localparam logic [PTR_WD-1:0] NULL_PTR = {PTR_WD{1'b1}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        EMIT  = 3'd3,
        FIN   = 3'd4
    } state_t;

endpackage

// File: rtl/ll_traverse_ctrl.sv
// Walks a singly linked list held in node memory, one read outstanding at a time,
// streaming each payload downstream and reporting node count and loop detection.
module ll_traverse_ctrl #(
    parameter int DATA_WIDTH    = ll_pkg::DATA_WIDTH,
    parameter int DATAMEM_DEPTH = ll_pkg::DATAMEM_DEPTH,
    parameter int PTR_WD        = $clog2(DATAMEM_DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [PTR_WD-1:0]          head_ptr,
    output logic                       busy,
    output logic                       mem_rd_vld,
    output logic [PTR_WD-1:0]          mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]      mem_rd_data,
    input  logic                       mem_rd_data_out_vld,
    output logic                       out_vld,
    output logic [DATA_WIDTH-PTR_WD-1:0] out_payload,
    output logic                       out_last,
    input  logic                       out_rdy,
    output logic                       done,
    output logic                       err_loop,
    output logic [PTR_WD:0]            node_count
);

    import ll_pkg::*;

    // The package terminator matches the default pointer width; other widths use all ones directly
    localparam logic [PTR_WD-1:0] NULL_LOC =
        (PTR_WD == $bits(NULL_PTR)) ? NULL_PTR : {PTR_WD{1'b1}};
    localparam logic [PTR_WD:0] CNT_ONE   = {{PTR_WD{1'b0}}, 1'b1};
    localparam logic [PTR_WD:0] CNT_LIMIT = (PTR_WD + 1)'(DATAMEM_DEPTH - 1);

    state_t                  state_r;
    state_t                  state_next_s;
    logic [PTR_WD-1:0]       ptr_r;
    logic [PTR_WD-1:0]       ptr_next_s;
    logic [PTR_WD:0]         count_r;
    logic [PTR_WD:0]         count_next_s;
    logic [DATA_WIDTH-1:0]   data_r;
    logic [DATA_WIDTH-1:0]   data_next_s;
    logic                    err_next_s;
    logic [PTR_WD-1:0]       next_ptr_s;
    logic                    last_s;

    assign next_ptr_s = data_r[PTR_WD-1:0];
    assign last_s     = (next_ptr_s == NULL_LOC);

    // Next-state and datapath update decode
    always_comb begin
        state_next_s = state_r;
        ptr_next_s   = ptr_r;
        count_next_s = count_r;
        data_next_s  = data_r;
        err_next_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    count_next_s = '0;
                    if (head_ptr == NULL_LOC) begin
                        state_next_s = FIN;
                    end else begin
                        ptr_next_s   = head_ptr;
                        state_next_s = ISSUE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                state_next_s = WAIT;
            end
            WAIT: begin
                if (mem_rd_data_out_vld) begin
                    data_next_s  = mem_rd_data;
                    state_next_s = EMIT;
                end else begin
                    state_next_s = WAIT;
                end
            end
            EMIT: begin
                if (out_rdy) begin
                    count_next_s = count_r + CNT_ONE;
                    if (last_s) begin
                        state_next_s = FIN;
                    end else if (count_next_s == CNT_LIMIT) begin
                        // A list can hold at most DEPTH-1 distinct nodes before revisiting one
                        err_next_s   = 1'b1;
                        state_next_s = FIN;
                    end else begin
                        ptr_next_s   = next_ptr_s;
                        state_next_s = ISSUE;
                    end
                end else begin
                    state_next_s = EMIT;
                end
            end
            FIN: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and traversal context registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            ptr_r   <= '0;
            count_r <= '0;
            data_r  <= '0;
        end else begin
            state_r <= state_next_s;
            ptr_r   <= ptr_next_s;
            count_r <= count_next_s;
            data_r  <= data_next_s;
        end
    end

    // Outputs registered from the next-state decode so they align with the state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            mem_rd_vld  <= 1'b0;
            mem_rd_addr <= '0;
            out_vld     <= 1'b0;
            out_payload <= '0;
            out_last    <= 1'b0;
            done        <= 1'b0;
            err_loop    <= 1'b0;
            node_count  <= '0;
        end else begin
            busy       <= (state_next_s != IDLE);
            mem_rd_vld <= (state_next_s == ISSUE);
            out_vld    <= (state_next_s == EMIT);
            out_last   <= (state_next_s == EMIT) && (data_next_s[PTR_WD-1:0] == NULL_LOC);
            done       <= (state_next_s == FIN);
            err_loop   <= (state_next_s == FIN) && err_next_s;
            if (state_next_s == ISSUE) begin
                mem_rd_addr <= ptr_next_s;
            end else begin
                mem_rd_addr <= mem_rd_addr;
            end
            if (state_next_s == EMIT) begin
                out_payload <= data_next_s[DATA_WIDTH-1:PTR_WD];
            end else begin
                out_payload <= out_payload;
            end
            if (state_next_s == FIN) begin
                node_count <= count_next_s;
            end else begin
                node_count <= node_count;
            end
        end
    end

endmodule

// File: tb/tb_ll_traverse_ctrl.sv
// Self-checking bench: node memory model plus a list-walking reference model that
// predicts the payload stream, node count, loop flag and cycle latency.
module tb_ll_traverse_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  head_ptr;
    logic        busy;
    logic        mem_rd_vld;
    logic [3:0]  mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic        mem_rd_data_out_vld;
    logic        out_vld;
    logic [11:0] out_payload;
    logic        out_last;
    logic        out_rdy;
    logic        done;
    logic        err_loop;
    logic [4:0]  node_count;

    logic [15:0] mem [16];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] exp_pay [$];
    bit          exp_last [$];
    int          exp_cnt;
    bit          exp_err;
    int          acc_n     = 0;
    int          hold_cnt  = 0;
    int          rdy_mode  = 0;
    bit          lat_rand  = 1'b0;
    bit          force_vld = 1'b0;

    ll_traverse_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .head_ptr            (head_ptr),
        .busy                (busy),
        .mem_rd_vld          (mem_rd_vld),
        .mem_rd_addr         (mem_rd_addr),
        .mem_rd_data         (mem_rd_data),
        .mem_rd_data_out_vld (mem_rd_data_out_vld),
        .out_vld             (out_vld),
        .out_payload         (out_payload),
        .out_last            (out_last),
        .out_rdy             (out_rdy),
        .done                (done),
        .err_loop            (err_loop),
        .node_count          (node_count)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: follow next pointers from head until NULL or the hop limit
    task automatic build_expected(input logic [3:0] h);
        logic [3:0]  p;
        logic [15:0] w;
        exp_pay.delete();
        exp_last.delete();
        exp_cnt = 0;
        exp_err = 1'b0;
        p = h;
        while (p != 4'hF) begin
            w = mem[p];
            exp_pay.push_back(w[15:4]);
            exp_last.push_back(w[3:0] == 4'hF);
            exp_cnt++;
            if (w[3:0] == 4'hF) break;
            if (exp_cnt == 15) begin
                exp_err = 1'b1;
                break;
            end
            p = w[3:0];
        end
    endtask

    // Node memory: answers each read after one cycle plus optional random extra delay
    initial begin : mem_model
        bit         pend;
        bit         r;
        logic [3:0] a;
        logic [3:0] paddr;
        int         lat_left;
        pend = 1'b0;
        paddr = 4'h0;
        lat_left = 0;
        mem_rd_data_out_vld = 1'b0;
        mem_rd_data = 16'h0000;
        forever begin
            @(posedge clk);
            r = mem_rd_vld;
            a = mem_rd_addr;
            #1;
            mem_rd_data_out_vld = force_vld;
            if (force_vld) mem_rd_data = 16'($urandom);
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (r) begin
                    pend = 1'b1;
                    paddr = a;
                    lat_left = lat_rand ? int'($urandom_range(0, 2)) : 0;
                end
                if (pend) begin
                    if (lat_left == 0) begin
                        mem_rd_data_out_vld = 1'b1;
                        mem_rd_data = mem[paddr];
                        pend = 1'b0;
                    end else begin
                        lat_left--;
                    end
                end
            end
        end
    end

    // Downstream ready: always, random, or a 5-cycle stall on the second node
    initial begin : rdy_drv
        out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_rdy = 1'b1;
                1: out_rdy = ($urandom_range(0, 3) != 0);
                2: begin
                    if (out_vld && acc_n == 1 && hold_cnt < 5) begin
                        out_rdy = 1'b0;
                        hold_cnt++;
                    end else begin
                        out_rdy = 1'b1;
                    end
                end
                default: out_rdy = 1'b1;
            endcase
        end
    end

    // Output scoreboard and handshake rules, sampled mid-cycle
    initial begin : monitor
        bit          prev_hold;
        logic [11:0] prev_pay;
        prev_hold = 1'b0;
        prev_pay = 12'h000;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_hold = 1'b0;
            end else begin
                check_value("one_outstanding", 32'(mem_rd_vld & out_vld), 32'd0);
                if (prev_hold) begin
                    check_value("hold_vld", 32'(out_vld), 32'd1);
                    check_value("hold_payload", 32'(out_payload), 32'(prev_pay));
                end
                if (out_vld && out_rdy) begin
                    check_value("payload_expected", 32'(exp_pay.size() > 0), 32'd1);
                    if (exp_pay.size() > 0) begin
                        check_value("payload", 32'(out_payload), 32'(exp_pay.pop_front()));
                        check_value("out_last", 32'(out_last), 32'(exp_last.pop_front()));
                    end
                    acc_n++;
                    prev_hold = 1'b0;
                end else begin
                    prev_hold = out_vld;
                    prev_pay = out_payload;
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_value({tag, "_busy"}, 32'(busy), 32'd0);
        check_value({tag, "_rd_vld"}, 32'(mem_rd_vld), 32'd0);
        check_value({tag, "_rd_addr"}, 32'(mem_rd_addr), 32'd0);
        check_value({tag, "_out_vld"}, 32'(out_vld), 32'd0);
        check_value({tag, "_payload"}, 32'(out_payload), 32'd0);
        check_value({tag, "_last"}, 32'(out_last), 32'd0);
        check_value({tag, "_done"}, 32'(done), 32'd0);
        check_value({tag, "_err"}, 32'(err_loop), 32'd0);
        check_value({tag, "_count"}, 32'(node_count), 32'd0);
    endtask

    // One traversal: start, wait for done (bounded), compare summary results
    task automatic run_trav(input logic [3:0] h, input int exp_lat, input bit pulse_busy);
        int cyc;
        int rd_n;
        bit seen;
        build_expected(h);
        acc_n = 0;
        hold_cnt = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        head_ptr = h;
        cyc = 0;
        rd_n = 0;
        seen = 1'b0;
        while (!seen && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (mem_rd_vld) rd_n++;
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                if (pulse_busy && busy && (cyc % 3 == 0)) begin
                    start = 1'b1;
                    head_ptr = 4'($urandom);
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check_value("done_seen", 32'(seen), 32'd1);
        check_value("node_count", 32'(node_count), 32'(exp_cnt));
        check_value("err_loop", 32'(err_loop), 32'(exp_err));
        check_value("read_count", 32'(rd_n), 32'(exp_cnt));
        check_value("payloads_left", 32'(exp_pay.size()), 32'd0);
        if (exp_lat >= 0) check_value("latency", 32'(cyc), 32'(exp_lat));
        repeat (3) begin
            @(negedge clk);
            check_value("done_pulse", 32'(done), 32'd0);
            check_value("idle_after", 32'(busy), 32'd0);
        end
    endtask

    initial begin : main
        logic [3:0] perm [15];
        logic [3:0] h;
        int         len;
        int         j;
        logic [3:0] t;
        int         rd;

        reset = 1'b1;
        start = 1'b0;
        head_ptr = 4'h0;
        for (int i = 0; i < 16; i++) mem[i] = 16'hFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Three-node list at full speed: 3 cycles per node, done two cycles later
        mem[2] = 16'hAAA5;
        mem[5] = 16'hBBB7;
        mem[7] = 16'hCCCF;
        run_trav(4'h2, 3 * 3 + 2, 1'b0);

        // Empty list
        run_trav(4'hF, 2, 1'b0);

        // Two-node cycle hits the hop limit
        mem[1] = 16'h0012;
        mem[2] = 16'h0021;
        run_trav(4'h1, 15 * 3 + 2, 1'b0);

        // Downstream stall of 5 cycles on node two
        mem[2] = 16'hAAA5;
        rdy_mode = 2;
        run_trav(4'h2, 3 * 3 + 2 + 5, 1'b0);
        rdy_mode = 0;

        // Start pulses while busy are ignored
        run_trav(4'h2, 3 * 3 + 2, 1'b1);

        // Reset during the WAIT of node two, then stray memory responses
        build_expected(4'h2);
        acc_n = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        head_ptr = 4'h2;
        @(posedge clk);
        #1;
        start = 1'b0;
        rd = 0;
        for (int c = 0; c < 50 && rd < 2; c++) begin
            @(negedge clk);
            if (mem_rd_vld) rd++;
        end
        check_value("second_read", 32'(rd), 32'd2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        exp_pay.delete();
        exp_last.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        force_vld = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_value("stray_out_vld", 32'(out_vld), 32'd0);
            check_value("stray_busy", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1;
        force_vld = 1'b0;

        // Randomized lists and loops with random memory latency and backpressure
        rdy_mode = 1;
        lat_rand = 1'b1;
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
            if (it % 2 == 0) begin
                for (int i = 0; i < 15; i++) perm[i] = 4'(i);
                for (int i = 14; i > 0; i--) begin
                    j = int'($urandom_range(0, i));
                    t = perm[i];
                    perm[i] = perm[j];
                    perm[j] = t;
                end
                len = int'($urandom_range(1, 8));
                for (int k = 0; k < len; k++)
                    mem[perm[k]][3:0] = (k == len - 1) ? 4'hF : perm[k + 1];
                h = perm[0];
            end else begin
                h = 4'($urandom);
            end
            run_trav(h, -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
